// File: rtl/memory_stage_pkg.sv
// Shared encodings for the memory stage: funct3 access sizes, result_src
// selects, the access FSM state type and the natural-alignment helper.
package memory_stage_pkg;

  // funct3 load/store access size and signedness
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // result_src selects carried to write-back
  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  // Natural alignment: bytes anywhere, halves on even, words on 4-byte boundary.
  // Only funct3[1:0] carries the size, so bu/hu reuse the b/h rules.
  function automatic logic is_aligned(input logic [2:0] funct3, input logic [1:0] off);
    logic ok;
    unique case (funct3[1:0])
      2'b00:   ok = 1'b1;
      2'b01:   ok = ~off[0];
      default: ok = (off == 2'b00);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load data formatter: picks the addressed byte/half lane out of the returned
// memory word and sign- or zero-extends it to XLEN.
//   rdata    : raw word from data memory
//   byte_off : address bits [1:0] of the access
//   funct3   : access size/sign
//   data     : extended load value
module load_extend
  import memory_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      byte_off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Lane select followed by extension
  always_comb begin
    lane_b = rdata[{byte_off, 3'b000} +: 8];
    lane_h = rdata[{byte_off[1], 4'b0000} +: 16];
    data   = rdata;
    unique case (funct3)
      F3_B:    data = {{(XLEN-8){lane_b[7]}}, lane_b};
      F3_H:    data = {{(XLEN-16){lane_h[15]}}, lane_h};
      F3_BU:   data = {{(XLEN-8){1'b0}}, lane_b};
      F3_HU:   data = {{(XLEN-16){1'b0}}, lane_h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// Pipeline MEM stage: issues data-memory requests for loads/stores, stalls the
// front of the pipeline while an access is outstanding, times out hung
// accesses, flags misaligned accesses and owns the MEM/WB pipeline register.
//   clk, srst                  : clock, async active-low reset
//   *_m                        : EX/MEM control and payload
//   flush_w                    : kill the instruction entering WB
//   dmem_req/we/addr/be/wdata  : data-memory request (word addressed, lane enables)
//   dmem_ack, dmem_rdata       : data-memory completion
//   stall_m                    : freeze upstream stages
//   misaligned_m, mem_err_m    : single-cycle exception pulses
//   *_w                        : MEM/WB register outputs
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic            clk,
  input  logic            srst,
  input  logic            valid_m,
  input  logic            reg_write_m,
  input  logic [1:0]      result_src_m,
  input  logic            mem_write_m,
  input  logic [2:0]      funct3_m,
  input  logic [4:0]      rd_m,
  input  logic [XLEN-1:0] alu_result_m,
  input  logic [XLEN-1:0] write_data_m,
  input  logic [XLEN-1:0] pc_plus4_m,
  input  logic            flush_w,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            stall_m,
  output logic            misaligned_m,
  output logic            mem_err_m,
  output logic            valid_w,
  output logic            reg_write_w,
  output logic [1:0]      result_src_w,
  output logic [4:0]      rd_w,
  output logic [XLEN-1:0] read_data_w,
  output logic [XLEN-1:0] alu_result_w,
  output logic [XLEN-1:0] pc_plus4_w
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);

  mem_state_e      state, state_next;
  logic [CW-1:0]   wait_cnt, wait_cnt_next, wait_cnt_inc;
  logic [1:0]      byte_off;
  logic            is_load, is_access, aligned, mem_op;
  logic            capture;
  logic [XLEN-1:0] load_data;

  assign byte_off  = alu_result_m[1:0];
  assign is_load   = (result_src_m == RES_LOAD);
  assign is_access = valid_m & (mem_write_m | is_load);
  assign aligned   = is_aligned(funct3_m, byte_off);
  assign mem_op    = is_access & aligned;

  // Saturating increment of the wait counter
  assign wait_cnt_inc = (wait_cnt == CW'(MAX_WAIT)) ? wait_cnt : wait_cnt + CW'(1);

  // State and wait-counter registers
  always_ff @(posedge clk or negedge srst) begin
    if (!srst) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // Next state, request and timeout. The request cycle in IDLE counts as the
  // first waited cycle, so entering WAIT loads 1 and the timeout fires after
  // MAX_WAIT stalled cycles. Reset gates req/err so they drop asynchronously.
  always_comb begin
    state_next    = state;
    wait_cnt_next = '0;
    dmem_req      = 1'b0;
    mem_err_m     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        dmem_req = mem_op;
        if (mem_op && !dmem_ack) begin
          state_next    = ST_WAIT;
          wait_cnt_next = CW'(1);
        end
      end
      ST_WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ack) begin
          state_next = ST_IDLE;
        end else if (wait_cnt == CW'(MAX_WAIT)) begin
          mem_err_m  = 1'b1;
          state_next = ST_IDLE;
        end else begin
          wait_cnt_next = wait_cnt_inc;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (!srst) begin
      dmem_req  = 1'b0;
      mem_err_m = 1'b0;
    end
  end

  assign misaligned_m = srst & is_access & ~aligned;
  assign stall_m      = dmem_req & ~dmem_ack & ~mem_err_m;

  assign dmem_we   = mem_write_m;
  assign dmem_addr = {alu_result_m[XLEN-1:2], 2'b00};

  // Lane enables and replicated store data
  always_comb begin
    dmem_be    = 4'b0000;
    dmem_wdata = write_data_m;
    unique case (funct3_m[1:0])
      2'b00: begin
        dmem_be    = 4'b0001 << byte_off;
        dmem_wdata = XLEN'({4{write_data_m[7:0]}});
      end
      2'b01: begin
        dmem_be    = 4'b0011 << byte_off;
        dmem_wdata = XLEN'({2{write_data_m[15:0]}});
      end
      default: begin
        dmem_be    = 4'b1111;
        dmem_wdata = write_data_m;
      end
    endcase
    if (!dmem_req) dmem_be = 4'b0000;
  end

  load_extend #(
    .XLEN(XLEN)
  ) u_load_extend (
    .rdata    (dmem_rdata),
    .byte_off (byte_off),
    .funct3   (funct3_m),
    .data     (load_data)
  );

  // Any stall, flush, timeout or misalignment sends a bubble to WB
  assign capture = ~stall_m & ~flush_w & ~mem_err_m & ~misaligned_m;

  // MEM/WB pipeline register
  always_ff @(posedge clk or negedge srst) begin
    if (!srst) begin
      valid_w      <= 1'b0;
      reg_write_w  <= 1'b0;
      result_src_w <= 2'b00;
      rd_w         <= 5'd0;
      read_data_w  <= '0;
      alu_result_w <= '0;
      pc_plus4_w   <= '0;
    end else if (capture) begin
      valid_w      <= valid_m;
      reg_write_w  <= reg_write_m;
      result_src_w <= result_src_m;
      rd_w         <= rd_m;
      read_data_w  <= is_load ? load_data : '0;
      alu_result_w <= alu_result_m;
      pc_plus4_w   <= pc_plus4_m;
    end else begin
      valid_w      <= 1'b0;
      reg_write_w  <= 1'b0;
      result_src_w <= 2'b00;
      rd_w         <= 5'd0;
      read_data_w  <= '0;
      alu_result_w <= '0;
      pc_plus4_w   <= '0;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: expected MEM/WB contents are queued when an
// instruction is driven and compared one clock later; request-side signals are
// checked mid-cycle.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        srst;
  logic        valid_m, reg_write_m, mem_write_m, flush_w, dmem_ack;
  logic [1:0]  result_src_m;
  logic [2:0]  funct3_m;
  logic [4:0]  rd_m;
  logic [31:0] alu_result_m, write_data_m, pc_plus4_m, dmem_rdata;
  logic        dmem_req, dmem_we, stall_m, misaligned_m, mem_err_m;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        valid_w, reg_write_w;
  logic [1:0]  result_src_w;
  logic [4:0]  rd_w;
  logic [31:0] read_data_w, alu_result_w, pc_plus4_w;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic [1:0]  result_src;
    logic [4:0]  rd;
    logic [31:0] read_data;
    logic [31:0] alu_result;
    logic [31:0] pc_plus4;
  } wb_t;

  wb_t sb[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  memory_stage #(.XLEN(32), .MAX_WAIT(15)) dut (
    .clk(clk), .srst(srst), .valid_m(valid_m), .reg_write_m(reg_write_m),
    .result_src_m(result_src_m), .mem_write_m(mem_write_m), .funct3_m(funct3_m),
    .rd_m(rd_m), .alu_result_m(alu_result_m), .write_data_m(write_data_m),
    .pc_plus4_m(pc_plus4_m), .flush_w(flush_w), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall_m(stall_m), .misaligned_m(misaligned_m), .mem_err_m(mem_err_m),
    .valid_w(valid_w), .reg_write_w(reg_write_w), .result_src_w(result_src_w),
    .rd_w(rd_w), .read_data_w(read_data_w), .alu_result_w(alu_result_w),
    .pc_plus4_w(pc_plus4_w)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic [1:0] rs, input logic mw,
                       input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [31:0] pc);
    valid_m = v; reg_write_m = rw; result_src_m = rs; mem_write_m = mw;
    funct3_m = f3; rd_m = rd; alu_result_m = alu; write_data_m = wd; pc_plus4_m = pc;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'b00, 1'b0, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0);
  endtask

  // Expected WB record for the currently driven instruction
  task automatic push_wb(input logic [31:0] rdata);
    wb_t e;
    e.valid = valid_m; e.reg_write = reg_write_m; e.result_src = result_src_m;
    e.rd = rd_m; e.read_data = rdata; e.alu_result = alu_result_m; e.pc_plus4 = pc_plus4_m;
    sb.push_back(e);
  endtask

  task automatic push_bubble();
    sb.push_back('0);
  endtask

  // Advance one clock and compare MEM/WB against the oldest expectation
  task automatic tick(input string tag);
    wb_t e, a;
    @(posedge clk);
    #1;
    a = '{valid_w, reg_write_w, result_src_w, rd_w, read_data_w, alu_result_w, pc_plus4_w};
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, a);
    end else begin
      e = sb.pop_front();
      assert (a === e) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, a, e);
      end
    end
  endtask

  initial begin
    srst = 1'b0; flush_w = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid_w", 32'(valid_w), 32'h0);
    chk("rst_read_data_w", read_data_w, 32'h0);
    chk("rst_pc_plus4_w", pc_plus4_w, 32'h0);
    chk("rst_req", 32'(dmem_req), 32'h0);
    srst = 1'b1;

    // sw, zero-wait ack
    drive(1'b1, 1'b0, 2'b00, 1'b1, 3'b010, 5'd0, 32'h104, 32'hDEADBEEF, 32'h1004);
    dmem_ack = 1'b1;
    #1;
    chk("sw_req", 32'(dmem_req), 32'h1);
    chk("sw_we", 32'(dmem_we), 32'h1);
    chk("sw_addr", dmem_addr, 32'h104);
    chk("sw_be", 32'(dmem_be), 32'hF);
    chk("sw_wdata", dmem_wdata, 32'hDEADBEEF);
    chk("sw_stall", 32'(stall_m), 32'h0);
    push_wb(32'h0);
    tick("sw_wb");

    // lb 0x103, ack after 3 stalled cycles
    drive(1'b1, 1'b1, 2'b01, 1'b0, 3'b000, 5'd5, 32'h103, 32'h0, 32'h1008);
    dmem_ack = 1'b0;
    #1;
    chk("lb_addr", dmem_addr, 32'h100);
    chk("lb_be", 32'(dmem_be), 32'h8);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("lb_stall%0d", i), 32'(stall_m), 32'h1);
      push_bubble();
      tick("lb_wait_wb");
      #1;
    end
    dmem_ack = 1'b1; dmem_rdata = 32'h80FF_0000;
    #1;
    chk("lb_ack_stall", 32'(stall_m), 32'h0);
    push_wb(32'hFFFFFF80);
    tick("lb_wb");

    // sh 0x102 with replicated half
    drive(1'b1, 1'b0, 2'b00, 1'b1, 3'b001, 5'd0, 32'h102, 32'h5555_1234, 32'h100C);
    #1;
    chk("sh_be", 32'(dmem_be), 32'hC);
    chk("sh_wdata", dmem_wdata, 32'h12341234);
    push_wb(32'h0);
    tick("sh_wb");

    // lhu / lh from the same address
    drive(1'b1, 1'b1, 2'b01, 1'b0, 3'b101, 5'd6, 32'h102, 32'h0, 32'h1010);
    dmem_rdata = 32'hABCD_0000;
    push_wb(32'h0000ABCD);
    tick("lhu_wb");
    drive(1'b1, 1'b1, 2'b01, 1'b0, 3'b001, 5'd7, 32'h102, 32'h0, 32'h1014);
    push_wb(32'hFFFFABCD);
    tick("lh_wb");

    // lbu lane 1, sb lane 1, lw aligned
    drive(1'b1, 1'b1, 2'b01, 1'b0, 3'b100, 5'd8, 32'h101, 32'h0, 32'h1018);
    dmem_rdata = 32'h0000_C300;
    push_wb(32'h000000C3);
    tick("lbu_wb");
    drive(1'b1, 1'b0, 2'b00, 1'b1, 3'b000, 5'd0, 32'h101, 32'h0000_00A5, 32'h101C);
    #1;
    chk("sb_be", 32'(dmem_be), 32'h2);
    chk("sb_wdata", dmem_wdata, 32'hA5A5A5A5);
    push_wb(32'h0);
    tick("sb_wb");
    drive(1'b1, 1'b1, 2'b01, 1'b0, 3'b010, 5'd9, 32'h108, 32'h0, 32'h1020);
    dmem_rdata = 32'h1234_5678;
    push_wb(32'h12345678);
    tick("lw_wb");

    // misaligned lw 0x106 with a stray ack
    drive(1'b1, 1'b1, 2'b01, 1'b0, 3'b010, 5'd10, 32'h106, 32'h0, 32'h1024);
    #1;
    chk("mis_pulse", 32'(misaligned_m), 32'h1);
    chk("mis_req", 32'(dmem_req), 32'h0);
    chk("mis_be", 32'(dmem_be), 32'h0);
    chk("mis_stall", 32'(stall_m), 32'h0);
    push_bubble();
    tick("mis_wb");

    // ALU op: no memory traffic, WB next clock; stray ack ignored
    drive(1'b1, 1'b1, 2'b00, 1'b0, 3'b010, 5'd11, 32'h3333_0001, 32'h0, 32'h1028);
    #1;
    chk("alu_mis", 32'(misaligned_m), 32'h0);
    chk("alu_req", 32'(dmem_req), 32'h0);
    chk("alu_stall", 32'(stall_m), 32'h0);
    push_wb(32'h0);
    tick("alu_wb");
    dmem_ack = 1'b0;

    // load with no ack: 15 stalled cycles then timeout
    drive(1'b1, 1'b1, 2'b01, 1'b0, 3'b010, 5'd12, 32'h200, 32'h0, 32'h102C);
    for (int i = 0; i < 15; i++) begin
      #1;
      chk($sformatf("to_stall%0d", i), 32'(stall_m), 32'h1);
      chk($sformatf("to_noerr%0d", i), 32'(mem_err_m), 32'h0);
      push_bubble();
      tick("to_wait_wb");
    end
    #1;
    chk("to_err", 32'(mem_err_m), 32'h1);
    chk("to_release", 32'(stall_m), 32'h0);
    push_bubble();
    tick("to_wb");
    // fresh zero-wait load proves the FSM is back in IDLE
    drive(1'b1, 1'b1, 2'b01, 1'b0, 3'b010, 5'd13, 32'h204, 32'h0, 32'h1030);
    dmem_ack = 1'b1; dmem_rdata = 32'h0BAD_F00D;
    #1;
    chk("to_err_clear", 32'(mem_err_m), 32'h0);
    chk("to_idle_stall", 32'(stall_m), 32'h0);
    push_wb(32'h0BADF00D);
    tick("to_idle_wb");

    // store acked together with flush: committed, WB bubble
    drive(1'b1, 1'b0, 2'b00, 1'b1, 3'b010, 5'd0, 32'h300, 32'hCAFE_0001, 32'h1034);
    flush_w = 1'b1;
    #1;
    chk("fl_req", 32'(dmem_req), 32'h1);
    chk("fl_stall", 32'(stall_m), 32'h0);
    push_bubble();
    tick("fl_wb");
    flush_w = 1'b0; dmem_ack = 1'b0;

    // reset while waiting
    drive(1'b1, 1'b1, 2'b01, 1'b0, 3'b010, 5'd14, 32'h400, 32'h0, 32'h1038);
    push_bubble();
    tick("rw_wb0");
    #1;
    chk("rw_req_before", 32'(dmem_req), 32'h1);
    srst = 1'b0;
    #1;
    chk("rw_req", 32'(dmem_req), 32'h0);
    chk("rw_stall", 32'(stall_m), 32'h0);
    chk("rw_err", 32'(mem_err_m), 32'h0);
    push_bubble();
    tick("rw_wb1");
    srst = 1'b1;
    idle();
    push_bubble();
    tick("rw_idle_wb");

    // reset clears a populated MEM/WB register mid-cycle
    drive(1'b1, 1'b1, 2'b00, 1'b0, 3'b010, 5'd15, 32'h5000_0000, 32'h0, 32'h103C);
    push_wb(32'h0);
    tick("pre_rst_wb");
    idle();
    #2;
    srst = 1'b0;
    #1;
    chk("rst2_valid_w", 32'(valid_w), 32'h0);
    chk("rst2_reg_write_w", 32'(reg_write_w), 32'h0);
    chk("rst2_rd_w", 32'(rd_w), 32'h0);
    chk("rst2_alu_w", alu_result_w, 32'h0);
    chk("rst2_pc_w", pc_plus4_w, 32'h0);
    srst = 1'b1;

    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
